// File: rtl/core_time_table_pkg.sv
// Shared types and constants for the per-core event-time table and its GVT min-tree.
package core_time_table_pkg;

   localparam int unsigned NUM_CORE_DFLT = 4;
   localparam int unsigned TIME_WID_DFLT = 16;

   // Core-id width; a single core still needs one bit to index
   function automatic int unsigned cid_wid(input int unsigned num_core);
      return (num_core > 1) ? $clog2(num_core) : 1;
   endfunction

   localparam int unsigned CID_WID_DFLT = cid_wid(NUM_CORE_DFLT);

   typedef logic [TIME_WID_DFLT-1:0] time_t;

   localparam time_t GVT_RESET_VALUE = '0;

endpackage

// File: rtl/core_time_table_gvt_monitor.sv
// Combinational min over valid per-core times and the pending-queue head.
module gvt_monitor
   import core_time_table_pkg::*;
#(
   parameter int unsigned NUM_CORE = NUM_CORE_DFLT,
   parameter int unsigned TIME_WID = TIME_WID_DFLT
) (
   input  logic [NUM_CORE*TIME_WID-1:0] core_times_i,
   input  logic [NUM_CORE-1:0]          core_vld_i,
   input  logic [TIME_WID-1:0]          next_event_i,
   output logic [TIME_WID-1:0]          gvt_min_c_o
);

   logic [TIME_WID-1:0] min_v;

   always_comb begin
      min_v = next_event_i;
      for (int unsigned i = 0; i < NUM_CORE; i++) begin
         if (core_vld_i[i] && (core_times_i[i*TIME_WID +: TIME_WID] < min_v)) begin
            min_v = core_times_i[i*TIME_WID +: TIME_WID];
         end
      end
   end

   assign gvt_min_c_o = min_v;

endmodule

// File: rtl/core_time_table.sv
// Per-core event-time table feeding the GVT min-tree, plus registered GVT/update strobe.
// Optional GVT regression flag enabled by defining GVT_REGRESS_CHECK_EN.
module core_time_table
   import core_time_table_pkg::*;
#(
   parameter  int unsigned NUM_CORE = NUM_CORE_DFLT,
   parameter  int unsigned TIME_WID = TIME_WID_DFLT,
   localparam int unsigned CID_WID  = cid_wid(NUM_CORE)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         dispatch_vld,
   input  logic [CID_WID-1:0]           dispatch_cid,
   input  logic [TIME_WID-1:0]          dispatch_time,
   output logic                         dispatch_rdy,
   input  logic                         retire_vld,
   input  logic [CID_WID-1:0]           retire_cid,
   input  logic [TIME_WID-1:0]          next_event,
   output logic [TIME_WID*NUM_CORE-1:0] core_times,
   output logic [NUM_CORE-1:0]          core_vld,
   output logic [CID_WID:0]             num_active,
   output logic [TIME_WID-1:0]          gvt,
   output logic                         gvt_update,
   output logic                         gvt_err
);

   localparam int unsigned CNT_WID = CID_WID + 1;

   logic [NUM_CORE-1:0][TIME_WID-1:0] times_q, times_d;
   logic [NUM_CORE-1:0]               vld_q, vld_d;
   logic [CNT_WID-1:0]                active_q, active_d;
   logic [TIME_WID-1:0]               gvt_q, gvt_d;
   logic                              upd_q, upd_d;
   logic                              dispatch_fire;
   logic                              retire_eff;
   logic [TIME_WID-1:0]               gvt_min;

   assign dispatch_rdy  = !vld_q[dispatch_cid];
   assign dispatch_fire = dispatch_vld && dispatch_rdy;
   // An idle-core retire (including one colliding with a dispatch to that core) is a no-op
   assign retire_eff    = retire_vld && vld_q[retire_cid];

   gvt_monitor #(
      .NUM_CORE (NUM_CORE),
      .TIME_WID (TIME_WID)
   ) u_gvt_monitor (
      .core_times_i (times_q),
      .core_vld_i   (vld_q),
      .next_event_i (next_event),
      .gvt_min_c_o  (gvt_min)
   );

   always_comb begin
      times_d  = times_q;
      vld_d    = vld_q;
      active_d = active_q;
      if (dispatch_fire) begin
         times_d[dispatch_cid] = dispatch_time;
         vld_d[dispatch_cid]   = 1'b1;
      end
      if (retire_eff) begin
         vld_d[retire_cid] = 1'b0;
      end
      case ({dispatch_fire, retire_eff})
         2'b10:   active_d = active_q + CNT_WID'(1);
         2'b01:   active_d = active_q - CNT_WID'(1);
         default: active_d = active_q;
      endcase
      gvt_d = gvt_min;
      upd_d = (gvt_d != gvt_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         times_q  <= '0;
         vld_q    <= '0;
         active_q <= '0;
         gvt_q    <= TIME_WID'(GVT_RESET_VALUE);
         upd_q    <= 1'b0;
      end else begin
         times_q  <= times_d;
         vld_q    <= vld_d;
         active_q <= active_d;
         gvt_q    <= gvt_d;
         upd_q    <= upd_d;
      end
   end

`ifdef GVT_REGRESS_CHECK_EN
   logic err_q, err_d;

   // Straggler detect: GVT about to move backwards once the table has been live
   always_comb begin
      err_d = err_q;
      if ((gvt_d < gvt_q) && ((active_q != '0) || (gvt_q != '0))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign gvt_err = err_q;
`else
   assign gvt_err = 1'b0;
`endif

   assign core_times = times_q;
   assign core_vld   = vld_q;
   assign num_active = active_q;
   assign gvt        = gvt_q;
   assign gvt_update = upd_q;

endmodule

// File: tb/tb_core_time_table.sv
// Directed self-checking bench for core_time_table (4 cores, 16-bit time).
module tb_core_time_table;

   logic        clk;
   logic        rst_n;
   logic        dispatch_vld;
   logic [1:0]  dispatch_cid;
   logic [15:0] dispatch_time;
   logic        dispatch_rdy;
   logic        retire_vld;
   logic [1:0]  retire_cid;
   logic [15:0] next_event;
   logic [63:0] core_times;
   logic [3:0]  core_vld;
   logic [2:0]  num_active;
   logic [15:0] gvt;
   logic        gvt_update;
   logic        gvt_err;

   int errors = 0;
   int checks = 0;

`ifdef GVT_REGRESS_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   core_time_table #(.NUM_CORE(4), .TIME_WID(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dispatch_vld  (dispatch_vld),
      .dispatch_cid  (dispatch_cid),
      .dispatch_time (dispatch_time),
      .dispatch_rdy  (dispatch_rdy),
      .retire_vld    (retire_vld),
      .retire_cid    (retire_cid),
      .next_event    (next_event),
      .core_times    (core_times),
      .core_vld      (core_vld),
      .num_active    (num_active),
      .gvt           (gvt),
      .gvt_update    (gvt_update),
      .gvt_err       (gvt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dispatch_vld  = 1'b0;
      dispatch_cid  = '0;
      dispatch_time = '0;
      retire_vld    = 1'b0;
      retire_cid    = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      next_event = 16'h0040;
      rst_n = 1'b0;
      step();
      checks++; if (core_vld !== 4'b0000) begin errors++; $display("FAIL reset_core_vld got=%b exp=0000", core_vld); end
      checks++; if (core_times !== 64'h0) begin errors++; $display("FAIL reset_core_times got=%h exp=0", core_times); end
      checks++; if (gvt !== 16'h0000) begin errors++; $display("FAIL reset_gvt got=%h exp=0000", gvt); end
      checks++; if (gvt_update !== 1'b0) begin errors++; $display("FAIL reset_gvt_update got=%b exp=0", gvt_update); end
      checks++; if (gvt_err !== 1'b0) begin errors++; $display("FAIL reset_gvt_err got=%b exp=0", gvt_err); end
      rst_n = 1'b1;
      step();
      checks++; if (gvt !== 16'h0040) begin errors++; $display("FAIL reset_first_gvt got=%h exp=0040", gvt); end
      checks++; if (gvt_update !== 1'b1) begin errors++; $display("FAIL reset_first_update got=%b exp=1", gvt_update); end
      step();
      checks++; if (gvt_update !== 1'b0) begin errors++; $display("FAIL reset_update_single got=%b exp=0", gvt_update); end
      checks++; if (num_active !== 3'd0) begin errors++; $display("FAIL reset_num_active got=%0d exp=0", num_active); end
   endtask

   task automatic test_dispatch();
      dispatch_vld = 1'b1; dispatch_cid = 2'd2; dispatch_time = 16'h0010;
      #1;
      checks++; if (dispatch_rdy !== 1'b1) begin errors++; $display("FAIL disp_rdy_idle got=%b exp=1", dispatch_rdy); end
      step();
      dispatch_vld = 1'b0;
      #1;
      checks++; if (core_vld !== 4'b0100) begin errors++; $display("FAIL disp_core_vld got=%b exp=0100", core_vld); end
      checks++; if (core_times[32 +: 16] !== 16'h0010) begin errors++; $display("FAIL disp_time2 got=%h exp=0010", core_times[32 +: 16]); end
      checks++; if (num_active !== 3'd1) begin errors++; $display("FAIL disp_num_active got=%0d exp=1", num_active); end
      checks++; if (gvt !== 16'h0040) begin errors++; $display("FAIL disp_gvt_lag got=%h exp=0040", gvt); end
      checks++; if (dispatch_rdy !== 1'b0) begin errors++; $display("FAIL disp_rdy_busy got=%b exp=0", dispatch_rdy); end
      step();
      checks++; if (gvt !== 16'h0010) begin errors++; $display("FAIL disp_gvt got=%h exp=0010", gvt); end
      checks++; if (gvt_update !== 1'b1) begin errors++; $display("FAIL disp_update got=%b exp=1", gvt_update); end
      retire_vld = 1'b1; retire_cid = 2'd2;
      step();
      retire_vld = 1'b0;
      step();
      checks++; if (gvt !== 16'h0040) begin errors++; $display("FAIL disp_cleanup_gvt got=%h exp=0040", gvt); end
   endtask

   task automatic test_retire();
      dispatch_vld = 1'b1; dispatch_cid = 2'd0; dispatch_time = 16'h0020;
      step();
      dispatch_cid = 2'd1; dispatch_time = 16'h0030;
      step();
      dispatch_vld = 1'b0;
      step();
      checks++; if (gvt !== 16'h0020) begin errors++; $display("FAIL ret_pre_gvt got=%h exp=0020", gvt); end
      checks++; if (num_active !== 3'd2) begin errors++; $display("FAIL ret_pre_active got=%0d exp=2", num_active); end
      retire_vld = 1'b1; retire_cid = 2'd0;
      step();
      retire_vld = 1'b0;
      checks++; if (core_vld !== 4'b0010) begin errors++; $display("FAIL ret_core_vld got=%b exp=0010", core_vld); end
      checks++; if (num_active !== 3'd1) begin errors++; $display("FAIL ret_active got=%0d exp=1", num_active); end
      checks++; if (gvt !== 16'h0020) begin errors++; $display("FAIL ret_gvt_lag got=%h exp=0020", gvt); end
      checks++; if (core_times[0 +: 16] !== 16'h0020) begin errors++; $display("FAIL ret_time_kept got=%h exp=0020", core_times[0 +: 16]); end
      step();
      checks++; if (gvt !== 16'h0030) begin errors++; $display("FAIL ret_gvt got=%h exp=0030", gvt); end
      checks++; if (gvt_update !== 1'b1) begin errors++; $display("FAIL ret_update got=%b exp=1", gvt_update); end
   endtask

   task automatic test_same_cycle();
      dispatch_vld = 1'b1; dispatch_cid = 2'd3; dispatch_time = 16'h0050;
      retire_vld = 1'b1; retire_cid = 2'd1;
      step();
      idle_inputs();
      checks++; if (core_vld !== 4'b1000) begin errors++; $display("FAIL same_core_vld got=%b exp=1000", core_vld); end
      checks++; if (num_active !== 3'd1) begin errors++; $display("FAIL same_active got=%0d exp=1", num_active); end
      checks++; if (core_times[48 +: 16] !== 16'h0050) begin errors++; $display("FAIL same_time3 got=%h exp=0050", core_times[48 +: 16]); end
      step();
      checks++; if (gvt !== 16'h0040) begin errors++; $display("FAIL same_gvt got=%h exp=0040", gvt); end
      checks++; if (gvt_update !== 1'b1) begin errors++; $display("FAIL same_update got=%b exp=1", gvt_update); end
      // Same idle cid: dispatch wins, retire is ignored
      dispatch_vld = 1'b1; dispatch_cid = 2'd2; dispatch_time = 16'h0060;
      retire_vld = 1'b1; retire_cid = 2'd2;
      step();
      idle_inputs();
      checks++; if (core_vld !== 4'b1100) begin errors++; $display("FAIL same_idle_vld got=%b exp=1100", core_vld); end
      checks++; if (num_active !== 3'd2) begin errors++; $display("FAIL same_idle_active got=%0d exp=2", num_active); end
   endtask

   task automatic test_no_effect();
      step();
      retire_vld = 1'b1; retire_cid = 2'd0;
      dispatch_vld = 1'b1; dispatch_cid = 2'd3; dispatch_time = 16'h0001;
      #1;
      checks++; if (dispatch_rdy !== 1'b0) begin errors++; $display("FAIL noeff_rdy got=%b exp=0", dispatch_rdy); end
      step();
      idle_inputs();
      checks++; if (core_vld !== 4'b1100) begin errors++; $display("FAIL noeff_core_vld got=%b exp=1100", core_vld); end
      checks++; if (num_active !== 3'd2) begin errors++; $display("FAIL noeff_active got=%0d exp=2", num_active); end
      checks++; if (core_times[48 +: 16] !== 16'h0050) begin errors++; $display("FAIL noeff_time3 got=%h exp=0050", core_times[48 +: 16]); end
      step();
      checks++; if (gvt !== 16'h0040) begin errors++; $display("FAIL noeff_gvt got=%h exp=0040", gvt); end
      checks++; if (gvt_update !== 1'b0) begin errors++; $display("FAIL noeff_update got=%b exp=0", gvt_update); end
   endtask

   task automatic test_next_event();
      next_event = 16'h0045;
      step();
      checks++; if (gvt !== 16'h0045) begin errors++; $display("FAIL ne_gvt got=%h exp=0045", gvt); end
      checks++; if (gvt_update !== 1'b1) begin errors++; $display("FAIL ne_update got=%b exp=1", gvt_update); end
      retire_vld = 1'b1; retire_cid = 2'd2;
      step();
      retire_cid = 2'd3;
      step();
      retire_vld = 1'b0;
      next_event = 16'hFFFF;
      step();
      checks++; if (num_active !== 3'd0) begin errors++; $display("FAIL ne_active got=%0d exp=0", num_active); end
      checks++; if (gvt !== 16'hFFFF) begin errors++; $display("FAIL ne_gvt_max got=%h exp=ffff", gvt); end
      checks++; if (gvt_update !== 1'b1) begin errors++; $display("FAIL ne_update_max got=%b exp=1", gvt_update); end
   endtask

   task automatic test_regress();
      rst_n = 1'b0;
      #1;
      checks++; if (gvt !== 16'h0000) begin errors++; $display("FAIL rg_async_gvt got=%h exp=0000", gvt); end
      checks++; if (core_times !== 64'h0) begin errors++; $display("FAIL rg_async_times got=%h exp=0", core_times); end
      next_event = 16'h0030;
      step();
      rst_n = 1'b1;
      step();
      checks++; if (gvt !== 16'h0030) begin errors++; $display("FAIL rg_gvt_start got=%h exp=0030", gvt); end
      checks++; if (gvt_err !== 1'b0) begin errors++; $display("FAIL rg_err_start got=%b exp=0", gvt_err); end
      dispatch_vld = 1'b1; dispatch_cid = 2'd0; dispatch_time = 16'h0010;
      step();
      idle_inputs();
      checks++; if (gvt_err !== 1'b0) begin errors++; $display("FAIL rg_err_early got=%b exp=0", gvt_err); end
      step();
      checks++; if (gvt !== 16'h0010) begin errors++; $display("FAIL rg_gvt_low got=%h exp=0010", gvt); end
      checks++; if (gvt_err !== ERR_EN) begin errors++; $display("FAIL rg_err_set got=%b exp=%b", gvt_err, ERR_EN); end
      retire_vld = 1'b1; retire_cid = 2'd0;
      step();
      retire_vld = 1'b0;
      step();
      step();
      checks++; if (gvt_err !== ERR_EN) begin errors++; $display("FAIL rg_err_sticky got=%b exp=%b", gvt_err, ERR_EN); end
      rst_n = 1'b0;
      #1;
      checks++; if (gvt_err !== 1'b0) begin errors++; $display("FAIL rg_err_clear got=%b exp=0", gvt_err); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      next_event = '0;
      idle_inputs();
      test_reset();
      test_dispatch();
      test_retire();
      test_same_cycle();
      test_no_effect();
      test_next_event();
      test_regress();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
